serial_subtractor: RTL

Parametrised, multi-cycle successor to the team's combinational half subtractor. Computes Diff = input1 − input2 − Bin on WIDTH-bit unsigned operands, processing SLICE bits per clock from LSB to MSB with a registered borrow between slices. It is a start/done handshaked datapath unit for designs that trade latency for area, and it supports multi-word subtraction by chaining Borr into Bin.

---
 rtl/serial_subtractor.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/serial_subtractor.sv
// Multi-cycle WIDTH-bit subtractor, SLICE bits per clock, LSB first.
// Optional signed-overflow flag: define SERIAL_SUB_OVF_EN.
module serial_subtractor #(
    parameter int WIDTH = 8,
    parameter int SLICE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] input1,
    input  logic [WIDTH-1:0] input2,
    input  logic             Bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Diff,
    output logic             Borr
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             Ovf
`endif
);

    localparam int STEPS = WIDTH / SLICE;
    localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             brw_q, brw_d;
    logic             borr_q, borr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [SLICE:0]   sub;
    logic [WIDTH-1:0] res_sh;
`ifdef SERIAL_SUB_OVF_EN
    logic             amsb_q, amsb_d;
    logic             bmsb_q, bmsb_d;
    logic             ovf_q, ovf_d;
`endif

    // Low slice of the shifting operands minus the running borrow.
    assign sub = {1'b0, a_q[SLICE-1:0]}
               - {1'b0, b_q[SLICE-1:0]}
               - {{SLICE{1'b0}}, brw_q};

    // Result fills from the top so slice k lands in place after the last step.
    generate
        if (SLICE < WIDTH) begin : g_shift
            assign res_sh = {sub[SLICE-1:0], res_q[WIDTH-1:SLICE]};
        end else begin : g_whole
            assign res_sh = sub[SLICE-1:0];
        end
    endgenerate

    // Next-state and datapath updates for the IDLE/RUN/DONE sequence.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        diff_d  = diff_q;
        brw_d   = brw_q;
        borr_d  = borr_q;
        cnt_d   = cnt_q;
`ifdef SERIAL_SUB_OVF_EN
        amsb_d  = amsb_q;
        bmsb_d  = bmsb_q;
        ovf_d   = ovf_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = input1;
                    b_d     = input2;
                    brw_d   = Bin;
                    cnt_d   = '0;
                    res_d   = '0;
`ifdef SERIAL_SUB_OVF_EN
                    amsb_d  = input1[WIDTH-1];
                    bmsb_d  = input2[WIDTH-1];
`endif
                    state_d = RUN;
                end
            end
            RUN: begin
                a_d   = a_q >> SLICE;
                b_d   = b_q >> SLICE;
                brw_d = sub[SLICE];
                res_d = res_sh;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(STEPS - 1)) begin
                    diff_d  = res_sh;
                    borr_d  = sub[SLICE];
`ifdef SERIAL_SUB_OVF_EN
                    ovf_d   = (amsb_q != bmsb_q)
                           && (res_sh[WIDTH-1] != amsb_q);
`endif
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            diff_q  <= '0;
            brw_q   <= 1'b0;
            borr_q  <= 1'b0;
            cnt_q   <= '0;
`ifdef SERIAL_SUB_OVF_EN
            amsb_q  <= 1'b0;
            bmsb_q  <= 1'b0;
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            diff_q  <= diff_d;
            brw_q   <= brw_d;
            borr_q  <= borr_d;
            cnt_q   <= cnt_d;
`ifdef SERIAL_SUB_OVF_EN
            amsb_q  <= amsb_d;
            bmsb_q  <= bmsb_d;
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);
    assign Diff = diff_q;
    assign Borr = borr_q;
`ifdef SERIAL_SUB_OVF_EN
    assign Ovf  = ovf_q;
`endif

endmodule
